// File: rtl/mult_hilo_unit_pkg.sv
// Shared controller-side definitions for the HI/LO multiply unit: default width,
// multiplier FSM states, write-back source and funct encodings.
package mult_hilo_unit_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_t;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_HI  = 2'b10;
  localparam logic [1:0] WB_LO  = 2'b11;

  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

endpackage

// File: rtl/mult_shift_add_core.sv
// Radix-2 shift-add multiplier: sign-magnitude operands, WIDTH run cycles, then
// one fix cycle that restores the product sign.
module mult_shift_add_core
  import mult_hilo_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               sgn,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic                 neg;
  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;

  // Magnitude as unsigned; the most negative value maps onto 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] x);
    logic signed [WIDTH-1:0] nx;
    nx = -x;
    return x[WIDTH-1] ? $unsigned(nx) : $unsigned(x);
  endfunction

  function automatic logic [2*WIDTH-1:0] fix_sign(input logic [2*WIDTH-1:0] p,
                                                  input logic n);
    return n ? (~p + 1'b1) : p;
  endfunction

  assign a_s = a;
  assign b_s = b;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (load) begin
          state <= RUN;
          cnt   <= CNT_W'(WIDTH - 1);
        end
        RUN: begin
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= FIX;
        end
        FIX:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && load) begin
      mcand  <= {{WIDTH{1'b0}}, (sgn ? mag(a_s) : a)};
      mplier <= sgn ? mag(b_s) : b;
      neg    <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
      acc    <= '0;
    end else if (state == RUN) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  assign done    = (state == FIX);
  assign product = fix_sign(acc, neg);

endmodule

// File: rtl/mult_hilo_unit.sv
// Dual-lane multiply front end: picks the younger lane's request, owns the
// architectural HI/LO registers and raises the hazard stall while busy.
module mult_hilo_unit
  import mult_hilo_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start1,
  input  logic             sgn1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             start2,
  input  logic             sgn2,
  input  logic [WIDTH-1:0] a2,
  input  logic [WIDTH-1:0] b2,
  input  logic             rd_hilo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall
);

  logic               core_load;
  logic               core_done;
  logic [2*WIDTH-1:0] core_product;
  logic               sel_sgn;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;

  // Lane 2 is younger in program order, so its product is the one that survives.
  always_comb begin
    sel_sgn = sgn1;
    sel_a   = a1;
    sel_b   = b1;
    if (start2) begin
      sel_sgn = sgn2;
      sel_a   = a2;
      sel_b   = b2;
    end
  end

  assign core_load = ~busy & (start1 | start2);

  mult_shift_add_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .reset   (reset),
    .load    (core_load),
    .sgn     (sel_sgn),
    .a       (sel_a),
    .b       (sel_b),
    .done    (core_done),
    .product (core_product)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      hi   <= '0;
      lo   <= '0;
      busy <= 1'b0;
    end else if (core_load) begin
      busy <= 1'b1;
    end else if (core_done) begin
      busy     <= 1'b0;
      {hi, lo} <= core_product;
    end
  end

  assign stall = busy & (start1 | start2 | rd_hilo);

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Directed-vector bench for mult_hilo_unit with hand-computed HI/LO products.
module tb_mult_hilo_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start1, sgn1, start2, sgn2, rd_hilo;
  logic [31:0] a1, b1, a2, b2;
  logic [31:0] hi, lo;
  logic        busy, stall;

  int checks = 0;
  int errors = 0;
  int cyc;

  mult_hilo_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .start1(start1), .sgn1(sgn1), .a1(a1), .b1(b1),
    .start2(start2), .sgn2(sgn2), .a2(a2), .b2(b2),
    .rd_hilo(rd_hilo), .hi(hi), .lo(lo), .busy(busy), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic s1, input logic g1, input logic [31:0] x1, input logic [31:0] y1,
                       input logic s2, input logic g2, input logic [31:0] x2, input logic [31:0] y2);
    @(negedge clk);
    start1 = s1; sgn1 = g1; a1 = x1; b1 = y1;
    start2 = s2; sgn2 = g2; a2 = x2; b2 = y2;
    @(posedge clk); #1;
    start1 = 1'b0; start2 = 1'b0;
  endtask

  task automatic wait_idle();
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; rd_hilo = 1'b1;
    start1 = 0; sgn1 = 0; a1 = 0; b1 = 0; start2 = 0; sgn2 = 0; a2 = 0; b2 = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
    @(negedge clk); reset = 1'b0; rd_hilo = 1'b0;
  endtask

  task automatic test_multu_max();
    issue(1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL multu_busy_rise: got %b want 1", busy); end
    wait_idle();
    checks++; if (cyc !== 33) begin errors++; $display("FAIL multu_busy_len: got %0d want 33", cyc); end
    checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_max_hi: got %h want fffffffe", hi); end
    checks++; if (lo !== 32'h00000001) begin errors++; $display("FAIL multu_max_lo: got %h want 00000001", lo); end
  endtask

  task automatic test_mult_signed();
    issue(1, 1, 32'hFFFFFFFD, 32'd5, 0, 0, 0, 0);
    wait_idle();
    checks++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFF1) begin errors++; $display("FAIL mult_m3x5: got %h_%h want ffffffff_fffffff1", hi, lo); end
    issue(1, 1, 32'h80000000, 32'h80000000, 0, 0, 0, 0);
    wait_idle();
    checks++; if ({hi, lo} !== 64'h40000000_00000000) begin errors++; $display("FAIL mult_minxmin: got %h_%h want 40000000_00000000", hi, lo); end
    issue(1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0);
    wait_idle();
    checks++; if ({hi, lo} !== 64'h00000000_00000001) begin errors++; $display("FAIL mult_m1xm1: got %h_%h want 00000000_00000001", hi, lo); end
    issue(0, 0, 0, 0, 1, 1, 32'd7, 32'hFFFFFFFA);
    wait_idle();
    checks++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFD6) begin errors++; $display("FAIL mult_7xm6: got %h_%h want ffffffff_ffffffd6", hi, lo); end
    issue(1, 0, 32'h80000000, 32'd2, 0, 0, 0, 0);
    wait_idle();
    checks++; if ({hi, lo} !== 64'h00000001_00000000) begin errors++; $display("FAIL multu_msbx2: got %h_%h want 00000001_00000000", hi, lo); end
  endtask

  task automatic test_dual_lane();
    issue(1, 0, 32'd2, 32'd3, 1, 0, 32'd7, 32'd6);
    wait_idle();
    checks++; if ({hi, lo} !== 64'd42) begin errors++; $display("FAIL dual_lane2_wins: got %h_%h want 0_2a", hi, lo); end
    repeat (40) @(posedge clk);
    #1;
    checks++; if ({busy, hi, lo} !== {1'b0, 64'd42}) begin errors++; $display("FAIL dual_lane1_dropped: got busy=%b %h_%h want busy=0 0_2a", busy, hi, lo); end
  endtask

  task automatic test_stall();
    int bad_stall;
    issue(1, 0, 32'd5, 32'd9, 0, 0, 0, 0);
    repeat (5) @(posedge clk);
    @(negedge clk); rd_hilo = 1'b1; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_rd_hilo: got %b want 1", stall); end
    checks++; if ({hi, lo} !== 64'd42) begin errors++; $display("FAIL stall_hilo_stable: got %h_%h want 0_2a", hi, lo); end
    @(negedge clk); rd_hilo = 1'b0; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_idle_lines: got %b want 0", stall); end
    @(negedge clk); start1 = 1'b1; sgn1 = 1'b0; a1 = 32'd100; b1 = 32'd3;
    bad_stall = 0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      #1; if (stall !== 1'b1) bad_stall++;
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (bad_stall !== 0) begin errors++; $display("FAIL stall_held_start: %0d cycles without stall, want 0", bad_stall); end
    checks++; if ({hi, lo} !== 64'd45) begin errors++; $display("FAIL stall_first_product: got %h_%h want 0_2d", hi, lo); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_after_busy: got %b want 0", stall); end
    @(posedge clk); #1;
    start1 = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_start_accepted: got busy=%b want 1", busy); end
    wait_idle();
    checks++; if ({hi, lo} !== 64'd300) begin errors++; $display("FAIL stall_second_product: got %h_%h want 0_12c", hi, lo); end
  endtask

  task automatic test_back_to_back();
    issue(0, 0, 0, 0, 1, 1, 32'hFFFFFFFE, 32'd3);
    wait_idle();
    checks++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFA) begin errors++; $display("FAIL b2b_first: got %h_%h want ffffffff_fffffffa", hi, lo); end
    issue(1, 0, 32'h00010000, 32'h00010000, 0, 0, 0, 0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_no_bubble: got busy=%b want 1", busy); end
    wait_idle();
    checks++; if (cyc !== 33) begin errors++; $display("FAIL b2b_busy_len: got %0d want 33", cyc); end
    checks++; if ({hi, lo} !== 64'h00000001_00000000) begin errors++; $display("FAIL b2b_second: got %h_%h want 00000001_00000000", hi, lo); end
  endtask

  task automatic test_reset_midrun();
    issue(1, 0, 32'd2, 32'h80000001, 0, 0, 0, 0);
    wait_idle();
    checks++; if ({hi, lo} !== 64'h00000001_00000002) begin errors++; $display("FAIL rst_prior_hilo: got %h_%h want 00000001_00000002", hi, lo); end
    issue(1, 0, 32'h0000FFFF, 32'h0000FFFF, 0, 0, 0, 0);
    repeat (9) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if ({busy, hi, lo} !== {1'b0, 64'd0}) begin errors++; $display("FAIL rst_midrun: got busy=%b %h_%h want busy=0 0_0", busy, hi, lo); end
    repeat (40) @(posedge clk);
    #1;
    checks++; if ({busy, hi, lo} !== {1'b0, 64'd0}) begin errors++; $display("FAIL rst_no_late_update: got busy=%b %h_%h want busy=0 0_0", busy, hi, lo); end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_mult_signed();
    test_dual_lane();
    test_stall();
    test_back_to_back();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_hilo_unit.md
Name: mult_hilo_unit

Overview:
- Iterative multiply unit that executes the multiply requests raised by the dual-issue decoder's MultStart/MultSgn outputs, one request per lane.
- Holds the architectural HI/LO registers that mfhi/mflo read.
- Sits beside the EX-stage ALUs.
- Asserts a stall to the hazard logic while a product is pending and either lane needs the unit.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH, split into HI and LO.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start1  in  1  lane-1 multiply request (MultStart)
- sgn1  in  1  lane-1 signed select (MultSgn); 1 = mult, 0 = multu
- a1, b1  in  WIDTH  lane-1 rs/rt operands
- start2  in  1  lane-2 multiply request (MultStart2)
- sgn2  in  1  lane-2 signed select (MultSgn2)
- a2, b2  in  WIDTH  lane-2 rs/rt operands
- rd_hilo  in  1  either lane is reading HI or LO this cycle (WBSrc 10/11)
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- busy  out  1  a multiply is in flight
- stall  out  1  pipeline hold request

Behaviour:
- Reset, synchronous and active-high, on clk:
  - hi = 0, lo = 0, busy = 0, stall = 0.
  - State returns to IDLE.
  - Any in-flight operation is discarded and HI/LO are not updated.
- State machine has three states: IDLE, RUN, FIX.
- Request sampling and lane selection:
  - Requests are sampled only in IDLE.
  - A request exists when start1 or start2 is high.
  - If both are high, lane 2 wins, because it is younger in program order and its product is the architectural HI/LO. The lane-1 request is dropped with no error.
- IDLE to RUN, on the edge that samples a request:
  - Latch the winning operands and sign mode.
  - If signed, latch |a| and |b| as WIDTH-bit unsigned magnitudes (|-2^(WIDTH-1)| = 2^(WIDTH-1)) and latch neg = a[msb] XOR b[msb]. If unsigned, latch a and b as-is with neg = 0.
  - Clear the 2*WIDTH accumulator.
  - Load the iteration counter with WIDTH-1.
- RUN:
  - Radix-2 shift-add, one multiplier bit per cycle, LSB first.
  - Counter decrements each cycle; RUN lasts exactly WIDTH cycles, then moves to FIX.
- FIX, one cycle:
  - If neg, product = two's complement of the accumulator (modulo 2^(2*WIDTH)); otherwise the accumulator.
  - {hi, lo} <= product; state goes to IDLE.
- Latency: start sampled at edge k, then WIDTH RUN cycles, then FIX; hi/lo update at edge k+WIDTH+1.
- busy:
  - Registered; rises at edge k and falls at edge k+WIDTH+1, so it is high for WIDTH+1 cycles.
  - Back-to-back: a new start presented in the cycle after busy falls is accepted at the next edge, with no bubble required.
- stall:
  - Combinational: stall = busy AND (start1 OR start2 OR rd_hilo).
  - A start seen while busy is ignored; the hazard logic must hold it until busy falls.
  - An rd_hilo while busy always stalls, so mfhi/mflo never read a stale product.
- hi/lo are stable except at the FIX edge; reads outside busy return the last completed product.
- Reset asserted mid-RUN or mid-FIX wins over the FIX update.
- Operand inputs are don't-care when no start is active.

Decomposition:
- Shared package (controller-side definitions):
  - WIDTH default constant.
  - State enum: IDLE, RUN, FIX.
  - WBSrc encodings: 00 ALU, 01 mem, 10 HI, 11 LO.
  - mult funct codes: 011000 mult, 011001 multu, 010000 mfhi, 010010 mflo.
- One sub-module, mult_shift_add_core:
  - Holds the accumulator, multiplicand/multiplier shift registers, counter and sign fix.
  - Interface: load/operands in, done/product out.
  - mult_hilo_unit keeps lane arbitration, HI/LO, busy and stall.

Test Plan:
- multu a1=0xFFFFFFFF, b1=0xFFFFFFFF -> after 33 cycles hi=0xFFFFFFFE, lo=0x00000001; busy high exactly 33 cycles.
- mult a1=-3 (0xFFFFFFFD), b1=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- mult a1=0x80000000, b1=0x80000000 -> hi=0x40000000, lo=0x00000000; mult -1 × -1 -> hi=0, lo=1.
- start1 (multu 2×3) and start2 (multu 7×6) in the same cycle -> hi=0, lo=42; lane-1 product never appears.
- rd_hilo pulsed and start1 re-asserted mid-RUN -> stall=1 each such cycle; hi/lo unchanged until FIX; the re-asserted start is accepted only after busy falls, with a correct second product.
- reset asserted at RUN cycle 10 of multu 0xFFFF×0xFFFF with prior hi/lo=0x1/0x2 -> next cycle hi=0, lo=0, busy=0; no later update.
